// File: rtl/axi2ahb_rdata_pack.sv
// Read-data return path of the AXI-to-AHB bridge: packs RATIO narrow AHB beats
// into one AXI word and queues finished words toward the AXI R channel.
module axi2ahb_rdata_pack #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int ERR_MODE       = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  output logic [AXI_ID_WIDTH-1:0]       RID,
  output logic [AXI_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY,
  input  logic [AHB_DATA_WIDTH-1:0]     HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP,
  input  logic [AXI_ID_WIDTH-1:0]       cmd_id_i,
  input  logic                          cmd_error_i,
  input  logic                          ctrl_rdata_valid_i,
  input  logic                          ctrl_rdata_last_i,
  output logic                          ctrl_rdata_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   rdata_level_o
);

  localparam int RATIO   = AXI_DATA_WIDTH / AHB_DATA_WIDTH;
  localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3;

  logic [LANE_W-1:0]         lane_reg;
  logic [AXI_DATA_WIDTH-1:0] pack_reg;
  logic [AXI_DATA_WIDTH-1:0] pack_next;
  logic                      err_pend_reg;
  logic                      word_err_reg;
  logic                      err_sticky_reg;
  logic [PTR_W-1:0]          wr_ptr_reg;
  logic [PTR_W-1:0]          rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic [ENTRY_W-1:0]        mem_reg [FIFO_DEPTH];

  logic               acc;
  logic               beat_err;
  logic               word_err_all;
  logic               word_done;
  logic               push;
  logic               pop;
  logic [1:0]         resp;
  logic [ENTRY_W-1:0] push_entry;

  assign ctrl_rdata_ready_o = (count_reg != CNT_W'(FIFO_DEPTH));
  assign RVALID             = (count_reg != '0);
  assign rdata_level_o      = count_reg;

  assign acc          = ctrl_rdata_valid_i & HREADY & ctrl_rdata_ready_o;
  assign beat_err     = HRESP | err_pend_reg | cmd_error_i;
  assign word_err_all = word_err_reg | beat_err;
  assign word_done    = acc & ((lane_reg == LANE_W'(RATIO - 1)) | ctrl_rdata_last_i);
  assign push         = word_done;
  assign pop          = RVALID & RREADY;

  // The completing beat's error is already folded into word_err_all, so the
  // sticky flag only needs its registered value here.
  assign resp = (word_err_all | ((ERR_MODE == 1) & err_sticky_reg)) ? 2'b10 : 2'b00;

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign pack_next[gi*AHB_DATA_WIDTH +: AHB_DATA_WIDTH] =
        (lane_reg == LANE_W'(gi)) ? HRDATA : pack_reg[gi*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
    end
  endgenerate

  assign push_entry = {cmd_id_i, pack_next, resp, ctrl_rdata_last_i};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      lane_reg     <= '0;
      pack_reg     <= '0;
      word_err_reg <= 1'b0;
    end else if (word_done) begin
      lane_reg     <= '0;
      pack_reg     <= '0;
      word_err_reg <= 1'b0;
    end else if (acc) begin
      lane_reg     <= lane_reg + LANE_W'(1);
      pack_reg     <= pack_next;
      word_err_reg <= word_err_all;
    end
  end

  // First cycle of a two-cycle AHB ERROR arms the flag; the beat that
  // finally completes consumes it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_pend_reg <= 1'b0;
    end else if (HRESP & ~HREADY) begin
      err_pend_reg <= 1'b1;
    end else if (acc) begin
      err_pend_reg <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_sticky_reg <= 1'b0;
    end else if (push & ctrl_rdata_last_i) begin
      err_sticky_reg <= 1'b0;
    end else if (acc & beat_err) begin
      err_sticky_reg <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign {RID, RDATA, RRESP, RLAST} = mem_reg[rd_ptr_reg];

endmodule
